// File: rtl/stv_stride_addr_gen.sv
// 2-D strided address generator: walks an inner (x) and outer (y) loop from a captured
// configuration and emits one address per valid/ready handshake, using accumulators only.
module stv_stride_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride_x,
  input  logic [ADDR_WIDTH-1:0] stride_y,
  input  logic [CNT_WIDTH-1:0]  count_x,
  input  logic [CNT_WIDTH-1:0]  count_y,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_x,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_stride_x;
  logic [ADDR_WIDTH-1:0] r_stride_y;
  logic [CNT_WIDTH-1:0]  r_cnt_x;
  logic [CNT_WIDTH-1:0]  r_cnt_y;
  logic [CNT_WIDTH-1:0]  r_x;
  logic [CNT_WIDTH-1:0]  r_y;
  logic                  r_valid;
  logic                  r_last_x;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_hs;
  logic [CNT_WIDTH-1:0]  w_x_inc;
  logic [CNT_WIDTH-1:0]  w_y_inc;
  logic [ADDR_WIDTH-1:0] w_row_next;

  assign w_hs       = r_valid & addr_ready;
  assign w_x_inc    = r_x + CNT_ONE;
  assign w_y_inc    = r_y + CNT_ONE;
  assign w_row_next = r_row_base + r_stride_y;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_row_base <= '0;
      r_stride_x <= '0;
      r_stride_y <= '0;
      r_cnt_x    <= '0;
      r_cnt_y    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
      r_last_x   <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !abort) begin
            r_state    <= S_RUN;
            r_addr     <= base;
            r_row_base <= base;
            r_stride_x <= stride_x;
            r_stride_y <= stride_y;
            r_cnt_x    <= count_x;
            r_cnt_y    <= count_y;
            r_x        <= '0;
            r_y        <= '0;
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_last_x   <= (count_x == '0);
            r_last     <= (count_x == '0) && (count_y == '0);
          end
        end
        S_RUN: begin
          // abort wins over a coincident handshake, so the final-beat path is checked second
          if (abort || (w_hs && r_last)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_last_x <= 1'b0;
            r_last   <= 1'b0;
          end else if (w_hs) begin
            if (r_x != r_cnt_x) begin
              r_x      <= w_x_inc;
              r_addr   <= r_addr + r_stride_x;
              r_last_x <= (w_x_inc == r_cnt_x);
              r_last   <= (w_x_inc == r_cnt_x) && (r_y == r_cnt_y);
            end else begin
              r_x        <= '0;
              r_y        <= w_y_inc;
              r_row_base <= w_row_next;
              r_addr     <= w_row_next;
              r_last_x   <= (r_cnt_x == '0);
              r_last     <= (r_cnt_x == '0) && (w_y_inc == r_cnt_y);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_valid = r_valid;
  assign addr       = r_addr;
  assign last_x     = r_last_x;
  assign last       = r_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_stv_stride_addr_gen.sv
// Self-checking bench for stv_stride_addr_gen: a table of walk configurations replayed
// against a queue of expected beats, plus hand-written abort and async-reset sequences.
module tb_stv_stride_addr_gen;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        abort;
  logic [15:0] base;
  logic [15:0] stride_x;
  logic [15:0] stride_y;
  logic [7:0]  count_x;
  logic [7:0]  count_y;
  logic        addr_valid;
  logic        addr_ready;
  logic [15:0] addr;
  logic        last_x;
  logic        last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] base;
    logic [15:0] sx;
    logic [15:0] sy;
    logic [7:0]  cx;
    logic [7:0]  cy;
    int          mode;       // 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
    int          exp_beats;
    logic [15:0] exp_first;
    logic [15:0] exp_final;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic        lx;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vecs[5];

  stv_stride_addr_gen #(.ADDR_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .arst(arst), .start(start), .abort(abort),
    .base(base), .stride_x(stride_x), .stride_y(stride_y),
    .count_x(count_x), .count_y(count_y),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .last_x(last_x), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one walk; abort_after >= 0 raises abort once that many beats have been accepted.
  task automatic run_walk(input vec_t v, input int abort_after);
    int          total;
    int          beats;
    int          cyc;
    logic        stalled;
    logic        aborted;
    logic        rdy;
    logic [15:0] pa;
    logic        plx;
    logic        pl;
    logic [15:0] final_a;
    beat_t       e;
    total   = (int'(v.cx) + 1) * (int'(v.cy) + 1);
    beats   = 0;
    cyc     = 0;
    stalled = 1'b0;
    aborted = 1'b0;
    pa      = '0;
    plx     = 1'b0;
    pl      = 1'b0;
    final_a = '0;
    exp_q.delete();
    for (int y = 0; y <= int'(v.cy); y++)
      for (int x = 0; x <= int'(v.cx); x++) begin
        e.a  = 16'(v.base + 16'(x) * v.sx + 16'(y) * v.sy);
        e.lx = (x == int'(v.cx));
        e.l  = (x == int'(v.cx)) && (y == int'(v.cy));
        exp_q.push_back(e);
      end
    chk("model_beats", 32'(total), 32'(v.exp_beats));

    @(negedge clk);
    start = 1'b1; abort = 1'b0; addr_ready = 1'b0;
    base = v.base; stride_x = v.sx; stride_y = v.sy; count_x = v.cx; count_y = v.cy;

    while (beats < total && !aborted) begin
      @(negedge clk);
      // scramble configuration and re-pulse start mid-walk; the walk must not notice
      start    = (cyc == 1) && (total >= 3);
      base     = 16'($urandom);
      stride_x = 16'($urandom);
      stride_y = 16'($urandom);
      count_x  = 8'($urandom);
      count_y  = 8'($urandom);
      chk("valid_in_walk", 32'(addr_valid), 32'd1);
      chk("busy_in_walk", 32'(busy), 32'd1);
      if (cyc == 0) chk("first_addr", 32'(addr), 32'(v.exp_first));
      if (stalled) begin
        chk("stall_addr", 32'(addr), 32'(pa));
        chk("stall_last", 32'({last_x, last}), 32'({plx, pl}));
      end
      rdy        = pick_ready(v.mode, cyc);
      addr_ready = rdy;
      if (abort_after >= 0 && beats == abort_after) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      if (addr_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got addr %0h, expected no beat", addr);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 32'(addr), 32'(e.a));
          chk("beat_last", 32'({last_x, last}), 32'({e.lx, e.l}));
        end
        final_a = addr;
        beats++;
      end
      stalled = addr_valid && !rdy;
      pa  = addr;
      plx = last_x;
      pl  = last;
      cyc++;
      if (cyc > 300) begin
        n_tests++; n_fail++;
        $display("FAIL walk_timeout: got %0d beats, expected %0d", beats, total);
        aborted = 1'b1;
      end
    end
    if (abort_after < 0) begin
      chk("beat_count", 32'(beats), 32'(v.exp_beats));
      chk("final_addr", 32'(final_a), 32'(v.exp_final));
    end

    @(negedge clk);
    start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    chk("end_valid", 32'(addr_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_low", 32'(done), 32'd0);
    chk("idle_valid", 32'(addr_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1, 0, 6, 16'h0100, 16'h0148};
    vecs[1] = '{16'h0100, 16'h0004, 16'h0040, 8'd2, 8'd1, 1, 6, 16'h0100, 16'h0148};
    vecs[2] = '{16'hFFFC, 16'h0008, 16'h0000, 8'd1, 8'd0, 0, 2, 16'hFFFC, 16'h0004};
    vecs[3] = '{16'h0020, 16'h0010, 16'h0100, 8'd0, 8'd0, 0, 1, 16'h0020, 16'h0020};
    vecs[4] = '{16'h1234, 16'hFFF0, 16'h0100, 8'd3, 8'd2, 2, 12, 16'h1234, 16'h1404};

    arst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    base = '0; stride_x = '0; stride_y = '0; count_x = '0; count_y = '0;
    #1;
    chk("rst_outputs", 32'({addr_valid, busy, done, last_x, last}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;

    // abort while idle must do nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_done", 32'(done), 32'd0);

    for (int i = 0; i < 5; i++) run_walk(vecs[i], -1);

    // abort coincident with the 4th handshake, then a fresh walk
    run_walk(vecs[0], 3);
    run_walk(vecs[2], -1);

    // asynchronous reset during a stall
    @(negedge clk);
    start = 1'b1; addr_ready = 1'b0;
    base = 16'h0300; stride_x = 16'h0002; stride_y = 16'h0010; count_x = 8'd3; count_y = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("stall_valid", 32'(addr_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 arst = 1'b1;
    #1;
    chk("arst_immediate", 32'({addr_valid, busy, done}), 32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    arst = 1'b0;
    run_walk(vecs[3], -1);
    run_walk(vecs[0], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
